// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM states, instruction
// classes, opcode/funct constants and ALU operation codes.
package multicycle_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXE    = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CL_NOP     = 3'd0,
        CL_R       = 3'd1,
        CL_IALU    = 3'd2,
        CL_LW      = 3'd3,
        CL_SW      = 3'd4,
        CL_ILLEGAL = 3'd5
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_NOP   = 6'b000000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLTU  = 6'b101011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b011;
    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_SLL = 3'b111;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// ctrl_decode: combinational instruction classifier; maps {opcode,funct} to
// an instruction class, the ALU operation and the immediate-extension select.
module ctrl_decode
    import multicycle_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_t    iclass,
    output logic [2:0] alu_op,
    output logic       imm_s
);

    // classify the instruction and pick its ALU operation
    always_comb begin
        iclass = CL_ILLEGAL;
        alu_op = '0;
        imm_s  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (funct == FN_NOP) begin
                    iclass = CL_NOP;
                end else begin
                    iclass = CL_R;
                    case (funct)
                        FN_ADD:  alu_op = ALU_ADD;
                        FN_SUB:  alu_op = ALU_SUB;
                        FN_AND:  alu_op = ALU_AND;
                        FN_OR:   alu_op = ALU_OR;
                        FN_XOR:  alu_op = ALU_XOR;
                        FN_NOR:  alu_op = ALU_NOR;
                        FN_SLTU: alu_op = ALU_SLT;
                        FN_SLLV: alu_op = ALU_SLL;
                        default: alu_op = '0;
                    endcase
                end
            end
            OP_ADDI:  begin iclass = CL_IALU; alu_op = ALU_ADD; imm_s = 1'b1; end
            OP_ANDI:  begin iclass = CL_IALU; alu_op = ALU_AND; end
            OP_XORI:  begin iclass = CL_IALU; alu_op = ALU_XOR; end
            OP_SLTIU: begin iclass = CL_IALU; alu_op = ALU_SLT; end
            OP_LW:    begin iclass = CL_LW;   alu_op = ALU_ADD; imm_s = 1'b1; end
            OP_SW:    begin iclass = CL_SW;   alu_op = ALU_ADD; imm_s = 1'b1; end
            default:  iclass = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM controller for a multicycle datapath
// (FETCH/DECODE/EXE/MEM/WB) with a retired-instruction counter.
// Optional feature macro: SINGLE_STEP_EN -- FETCH waits for a step pulse.
module multicycle_ctrl
    import multicycle_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        step,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_write,
    output logic [2:0]  alu_op,
    output logic        rd_rt_s,
    output logic        imm_s,
    output logic        rt_imm_s,
    output logic        alu_mem_s,
    output logic        instr_done,
    output logic        illegal,
    output logic [31:0] inst_cnt
);

    state_t     state, state_next;
    iclass_t    cls_q;
    logic [2:0] aop_q;
    logic       imm_q;

    iclass_t    dec_class;
    logic [2:0] dec_alu_op;
    logic       dec_imm_s;

    ctrl_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .iclass (dec_class),
        .alu_op (dec_alu_op),
        .imm_s  (dec_imm_s)
    );

`ifndef SINGLE_STEP_EN
    logic step_unused;
    assign step_unused = step;
`endif

    // state register, class latch (captured in DECODE) and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            cls_q    <= CL_NOP;
            aop_q    <= '0;
            imm_q    <= 1'b0;
            inst_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == DECODE) begin
                cls_q <= dec_class;
                aop_q <= dec_alu_op;
                imm_q <= dec_imm_s;
            end
            if (instr_done) begin
                inst_cnt <= inst_cnt + 32'd1;
            end
        end
    end

    // next-state and outputs; everything is forced low while rst is high so
    // a pending reg_write/mem_write is dropped in the reset cycle itself
    always_comb begin
        state_next = state;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        alu_op     = '0;
        rd_rt_s    = 1'b0;
        imm_s      = 1'b0;
        rt_imm_s   = 1'b0;
        alu_mem_s  = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (!rst) begin
            if (state == EXE || state == MEM || state == WB) begin
                alu_op    = aop_q;
                imm_s     = imm_q;
                rd_rt_s   = (cls_q != CL_R);
                rt_imm_s  = (cls_q != CL_R);
                alu_mem_s = (cls_q == CL_LW);
            end
            case (state)
                FETCH: begin
`ifdef SINGLE_STEP_EN
                    if (step) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        state_next = DECODE;
                    end
`else
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
`endif
                end
                DECODE: begin
                    case (dec_class)
                        CL_NOP: begin
                            instr_done = 1'b1;
                            state_next = FETCH;
                        end
                        CL_ILLEGAL: begin
                            illegal    = 1'b1;
                            state_next = FETCH;
                        end
                        default: state_next = EXE;
                    endcase
                end
                EXE: begin
                    if (cls_q == CL_LW || cls_q == CL_SW) state_next = MEM;
                    else                                  state_next = WB;
                end
                MEM: begin
                    if (cls_q == CL_SW) begin
                        mem_write  = 1'b1;
                        instr_done = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = WB;
                    end
                end
                WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    state_next = FETCH;
                end
                default: state_next = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. Each directed step pushes the
// expected per-cycle outputs into a scoreboard queue, which is then drained
// one clock at a time against the DUT. Build with SINGLE_STEP_EN to also
// exercise the single-step mode.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        step;
    logic        pc_write, ir_write, reg_write, mem_write;
    logic [2:0]  alu_op;
    logic        rd_rt_s, imm_s, rt_imm_s, alu_mem_s;
    logic        instr_done, illegal;
    logic [31:0] inst_cnt;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .step       (step),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .alu_op     (alu_op),
        .rd_rt_s    (rd_rt_s),
        .imm_s      (imm_s),
        .rt_imm_s   (rt_imm_s),
        .alu_mem_s  (alu_mem_s),
        .instr_done (instr_done),
        .illegal    (illegal),
        .inst_cnt   (inst_cnt)
    );

    always #5 clk = ~clk;

    // {pc_write, ir_write, reg_write, mem_write, alu_op, rd_rt_s, imm_s,
    //  rt_imm_s, alu_mem_s, instr_done, illegal}
    logic [12:0] obs;
    assign obs = {pc_write, ir_write, reg_write, mem_write, alu_op, rd_rt_s,
                  imm_s, rt_imm_s, alu_mem_s, instr_done, illegal};

    typedef struct packed {
        logic        rst;
        logic        step;
        logic [12:0] vec;
        logic [31:0] cnt;
    } ent_t;

    typedef enum int {K_R, K_IALU, K_LW, K_SW, K_NOP, K_ILL} kind_t;

    ent_t        sb[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    logic [31:0] cnt_m      = '0;
    string       cur_tag    = "";

`ifdef SINGLE_STEP_EN
    localparam logic FETCH_STEP = 1'b1;
`else
    localparam logic FETCH_STEP = 1'b0;
`endif

    function automatic logic [12:0] mk(input logic pc, input logic ir,
                                       input logic rw, input logic mw,
                                       input logic [2:0] aop, input logic rdrt,
                                       input logic im, input logic rtim,
                                       input logic am, input logic dn,
                                       input logic il);
        return {pc, ir, rw, mw, aop, rdrt, im, rtim, am, dn, il};
    endfunction

    task automatic push(input logic r, input logic s, input logic [12:0] v);
        ent_t e;
        e.rst  = r;
        e.step = s;
        e.vec  = v;
        e.cnt  = cnt_m;
        sb.push_back(e);
    endtask

    // entered just after a rising edge; applies inputs, checks at the falling edge
    task automatic drain();
        ent_t e;
        while (sb.size() > 0) begin
            e    = sb.pop_front();
            rst  = e.rst;
            step = e.step;
            @(negedge clk);
            compared++;
            assert (obs === e.vec) else begin
                mismatched++;
                $error("FAIL %s cyc%0d outputs got=%b exp=%b", cur_tag, cyc, obs, e.vec);
            end
            compared++;
            assert (inst_cnt === e.cnt) else begin
                mismatched++;
                $error("FAIL %s cyc%0d inst_cnt got=%0d exp=%0d", cur_tag, cyc, inst_cnt, e.cnt);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // queue the full expected cycle sequence of one instruction; cycles=-1 means complete
    task automatic push_instr(input kind_t k, input logic [2:0] aop, input logic im,
                              input int stop_after);
        logic [12:0] sel;
        int n = 0;
        push(1'b0, FETCH_STEP, mk(1, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
        n++;
        if (stop_after >= 0 && n >= stop_after) return;
        case (k)
            K_NOP: begin
                push(1'b0, 1'b0, mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0));
                cnt_m++;
            end
            K_ILL: push(1'b0, 1'b0, mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1));
            default: begin
                push(1'b0, 1'b0, '0);  // DECODE: no strobes, selects low
                n++;
                if (stop_after >= 0 && n >= stop_after) return;
                sel = mk(0, 0, 0, 0, aop, k != K_R, im, k != K_R, k == K_LW, 0, 0);
                push(1'b0, 1'b0, sel);  // EXE
                n++;
                if (stop_after >= 0 && n >= stop_after) return;
                if (k == K_LW) push(1'b0, 1'b0, sel);  // MEM
                if (k == K_SW) begin
                    push(1'b0, 1'b0, sel | mk(0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 1, 0));
                end else begin
                    push(1'b0, 1'b0, sel | mk(0, 0, 1, 0, 3'b000, 0, 0, 0, 0, 1, 0));
                end
                cnt_m++;
            end
        endcase
    endtask

    task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input kind_t k, input logic [2:0] aop, input logic im);
        cur_tag = tag;
        opcode  = op;
        funct   = fn;
        push_instr(k, aop, im, -1);
        drain();
    endtask

    initial begin
        rst    = 1'b1;
        step   = 1'b0;
        opcode = 6'b000000;
        funct  = 6'b100000;
        @(posedge clk);
        #1;

        // reset held: everything low, counter cleared
        cur_tag = "reset";
        push(1'b1, 1'b0, '0);
        push(1'b1, 1'b1, '0);
        drain();

        // R-type ALU ops
        run("add",   6'b000000, 6'b100000, K_R, 3'b100, 1'b0);
        run("sub",   6'b000000, 6'b100010, K_R, 3'b101, 1'b0);
        run("and",   6'b000000, 6'b100100, K_R, 3'b000, 1'b0);
        run("nor",   6'b000000, 6'b100111, K_R, 3'b011, 1'b0);
        run("sltu",  6'b000000, 6'b101011, K_R, 3'b110, 1'b0);
        run("sllv",  6'b000000, 6'b000100, K_R, 3'b111, 1'b0);
        // immediate ALU ops
        run("addi",  6'b001000, 6'b010101, K_IALU, 3'b100, 1'b1);
        run("andi",  6'b001100, 6'b000000, K_IALU, 3'b000, 1'b0);
        run("xori",  6'b001110, 6'b111111, K_IALU, 3'b010, 1'b0);
        run("sltiu", 6'b001011, 6'b000001, K_IALU, 3'b110, 1'b0);
        // memory, nop, illegal
        run("lw",    6'b100011, 6'b000000, K_LW, 3'b100, 1'b1);
        run("sw",    6'b101011, 6'b000000, K_SW, 3'b100, 1'b1);
        run("nop",   6'b000000, 6'b000000, K_NOP, 3'b000, 1'b0);
        run("ill3f", 6'b111111, 6'b000000, K_ILL, 3'b000, 1'b0);
        run("ill02", 6'b000010, 6'b100000, K_ILL, 3'b000, 1'b0);
        run("sw2",   6'b101011, 6'b111111, K_SW, 3'b100, 1'b1);
        run("add2",  6'b000000, 6'b100000, K_R, 3'b100, 1'b0);

        // reset asserted in the WB cycle of addi: reg_write suppressed, counter cleared
        cur_tag = "addi_rst";
        opcode  = 6'b001000;
        funct   = 6'b000000;
        push_instr(K_IALU, 3'b100, 1'b1, 3);
        push(1'b1, 1'b0, '0);
        drain();
        cnt_m = '0;
        run("after_rst", 6'b000000, 6'b100110, K_R, 3'b010, 1'b0);
        run("lw2",       6'b100011, 6'b000000, K_LW, 3'b100, 1'b1);

`ifdef SINGLE_STEP_EN
        // no step for 10 cycles: controller parks in FETCH
        cur_tag = "stall";
        for (int i = 0; i < 10; i++) push(1'b0, 1'b0, '0);
        drain();
        // a single step pulse runs exactly one instruction, then it parks again
        run("step_one", 6'b000000, 6'b100101, K_R, 3'b001, 1'b0);
        cur_tag = "stall2";
        for (int i = 0; i < 4; i++) push(1'b0, 1'b0, '0);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // watchdog so the bench always ends on its own
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port opcode, input, 6, instcode[31:26] from the external instruction register.
REQ-004 SHALL have port funct, input, 6, instcode[5:0] from the external instruction register.
REQ-005 SHALL have port step, input, 1, single-step advance pulse; used only per REQ-030.
REQ-006 SHALL have port pc_write, output, 1, PC <= PC+4 strobe.
REQ-007 SHALL have port ir_write, output, 1, instruction register load strobe.
REQ-008 SHALL have port reg_write, output, 1, register-file write strobe.
REQ-009 SHALL have port mem_write, output, 1, data-RAM write strobe.
REQ-010 SHALL have ports alu_op (output, 3), rd_rt_s, imm_s, rt_imm_s and alu_mem_s (outputs, 1 each), with the datapath mux meanings.
REQ-011 SHALL have ports instr_done (output, 1), illegal (output, 1) and inst_cnt (output, 32), where inst_cnt counts retired instructions.

Function
REQ-012 SHALL implement Moore FSM states FETCH, DECODE, EXE, MEM, WB, with encodings 0-4.
REQ-013 SHALL transition FETCH -> DECODE unconditionally, asserting ir_write=1 and pc_write=1 for exactly that cycle.
REQ-014 SHALL, in DECODE, classify {opcode,funct}: R (opcode 0, funct != 0), IALU (001000, 001100, 001110, 001011), LW (100011), SW (101011), NOP (opcode 0, funct 0) or ILLEGAL (anything else); the class SHALL be latched for the rest of the instruction.
REQ-015 SHALL go DECODE -> FETCH for NOP or ILLEGAL, and DECODE -> EXE otherwise.
REQ-016 SHALL go EXE -> WB for R/IALU, and EXE -> MEM for LW/SW.
REQ-017 SHALL go MEM -> WB for LW and MEM -> FETCH for SW, with mem_write=1 only in MEM for SW.
REQ-018 SHALL go WB -> FETCH, with reg_write=1 only in WB.
REQ-019 SHALL give instruction latency in cycles of R=4, IALU=4, LW=5, SW=4, NOP/ILLEGAL=2.
REQ-020 SHALL map R funct to alu_op as: 100000->100, 100010->101, 100100->000, 100101->001, 100110->010, 100111->011, 101011->110, 000100->111.
REQ-021 SHALL map I opcodes to alu_op as: 001000->100 with imm_s=1; 001100->000, 001110->010 and 001011->110 with imm_s=0; LW/SW->100 with imm_s=1.
REQ-022 SHALL drive rd_rt_s=1 and rt_imm_s=1 for IALU/LW/SW and 0 for R; alu_mem_s=1 only for LW.
REQ-023 SHALL hold alu_op and the mux selects stable from EXE through the last state of the instruction, and drive them 0 in FETCH and DECODE.
REQ-024 SHALL pulse instr_done for one cycle in the final state of R/IALU/LW/SW/NOP, and increment inst_cnt in that same cycle.
REQ-025 SHALL make inst_cnt wrap from 0xFFFFFFFF to 0 with no flag.
REQ-026 SHALL pulse illegal for one cycle in DECODE for the ILLEGAL class, with no increment of inst_cnt and no strobes.

Reset
REQ-027 SHALL, with rst=1 at a clock edge in any state, set state=FETCH, inst_cnt=0 and the latched class=NOP.
REQ-028 SHALL force all strobes and selects to 0 while rst=1, which also aborts a pending reg_write or mem_write mid-instruction.
REQ-029 SHALL start the first fetch in the first cycle after rst deasserts.

Configuration
REQ-030 SHALL, with SINGLE_STEP_EN defined, stall in FETCH (all strobes 0) until step=1 is sampled, then perform the FETCH actions in that cycle; one step pulse yields one instruction.
REQ-031 SHALL, without SINGLE_STEP_EN, ignore step and run continuously.

Structure
REQ-032 SHALL place the state encodings, class encodings, opcode/funct constants and alu_op constants in shared package multicycle_pkg.
REQ-033 SHALL contain exactly one sub-module, ctrl_decode: combinational {opcode,funct} -> class, alu_op, imm_s.

Verification
REQ-034 SHALL cover: rst released, opcode=000000 funct=100000 -> ir_write/pc_write at cycle 0, reg_write=1 at cycle 3 with alu_op=100, instr_done at cycle 3, inst_cnt=1.
REQ-035 SHALL cover: opcode=100011 -> mem_write never 1, alu_mem_s=1 and reg_write=1 at cycle 4, latency 5.
REQ-036 SHALL cover: opcode=101011 -> mem_write=1 at cycle 3 only, reg_write never 1, next FETCH at cycle 4.
REQ-037 SHALL cover: opcode=111111 -> illegal pulse at cycle 1, back to FETCH at cycle 2, inst_cnt unchanged.
REQ-038 SHALL cover: rst asserted during WB of addi -> reg_write=0 that cycle, state FETCH and inst_cnt=0 next cycle.
REQ-039 SHALL cover: SINGLE_STEP_EN defined, step low for 10 cycles -> no pc_write; one step pulse -> exactly one instr_done.
